// File: rtl/reg_op_ctrl.sv
// rtl/reg_op_ctrl.sv - register-file instruction sequencer (IDLE/READ/EXEC/WRITE); option macro REG_OP_CTRL_BACK2BACK_EN
module reg_op_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  output logic       instr_ready,
  input  logic [7:0] alu_res,
  output logic [1:0] DIR_A,
  output logic [1:0] DIR_B,
  output logic [1:0] DIR_WR,
  output logic [7:0] DI,
  output logic       EN,
  output logic [1:0] ALU_OP,
  output logic       busy,
  output logic       done,
  output logic [7:0] ops_cnt
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  state_t     state;
  state_t     state_nxt;
  logic       ready_q;
  logic       ready_nxt;
  logic       accept;
  logic [1:0] op_q;
  logic [1:0] rd_q;
  logic [7:0] result;

  // ready is registered so it stays low on every reset edge and rises one edge later
  assign accept = instr_valid && ready_q;

  // next-state and next-ready decode
  always_comb begin
    state_nxt = state;
    ready_nxt = 1'b0;
    case (state)
      IDLE:  if (accept) state_nxt = READ;
      READ:  state_nxt = EXEC;
      EXEC:  state_nxt = WRITE;
      WRITE: begin
`ifdef REG_OP_CTRL_BACK2BACK_EN
        state_nxt = accept ? READ : IDLE;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
`ifdef REG_OP_CTRL_BACK2BACK_EN
    ready_nxt = (state_nxt == IDLE) || (state_nxt == WRITE);
`else
    ready_nxt = (state_nxt == IDLE);
`endif
  end

  // state register and registered ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= ready_nxt;
    end
  end

  // datapath: each field is loaded on the edge entering the state that drives it, then held
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q    <= '0;
      rd_q    <= '0;
      DIR_A   <= '0;
      DIR_B   <= '0;
      DIR_WR  <= '0;
      ALU_OP  <= '0;
      result  <= '0;
      ops_cnt <= '0;
    end else begin
      if (accept) begin
        op_q  <= instr[7:6];
        DIR_A <= instr[5:4];
        DIR_B <= instr[3:2];
        rd_q  <= instr[1:0];
      end
      if (state == READ) ALU_OP <= op_q;
      if (state == EXEC) begin
        result <= alu_res;
        DIR_WR <= rd_q;
      end
      if (state == WRITE) ops_cnt <= ops_cnt + 8'd1;
    end
  end

  assign instr_ready = ready_q;
  assign DI          = result;
  assign EN          = (state == WRITE);
  assign done        = (state == WRITE);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_reg_op_ctrl.sv
// tb/tb_reg_op_ctrl.sv - randomized self-checking bench for reg_op_ctrl with register-file/ALU model
module tb_reg_op_ctrl;

`ifdef REG_OP_CTRL_BACK2BACK_EN
  localparam int PERIOD = 3;
`else
  localparam int PERIOD = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic [7:0] instr = '0;
  logic       instr_ready;
  logic [7:0] alu_res;
  logic [1:0] DIR_A, DIR_B, DIR_WR, ALU_OP;
  logic [7:0] DI, ops_cnt;
  logic       EN, busy, done;

  int vectors = 0;
  int miscompares = 0;

  logic       force_alu = 1'b0;
  logic       load_en = 1'b0;
  logic [1:0] load_addr = '0;
  logic [7:0] load_data = '0;
  logic       spacing_chk = 1'b0;

  logic [7:0] rf [4];
  logic [7:0] ref_rf [4];
  typedef struct {logic [1:0] rd; logic [7:0] val;} wr_t;
  wr_t        exp_q [$];
  logic [7:0] ref_cnt = '0;
  int         done_cnt = 0;
  int         cyc = 0;
  int         prev_acc = 0;
  bit         have_prev = 0;

  reg_op_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_res(alu_res), .DIR_A(DIR_A), .DIR_B(DIR_B),
    .DIR_WR(DIR_WR), .DI(DI), .EN(EN), .ALU_OP(ALU_OP), .busy(busy),
    .done(done), .ops_cnt(ops_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // bench register file and combinational ALU
  assign alu_res = force_alu ? 8'h5A : alu_f(ALU_OP, rf[DIR_A], rf[DIR_B]);
  always @(posedge clk) begin
    if (load_en) rf[load_addr] <= load_data;
    else if (EN) rf[DIR_WR] <= DI;
  end

  // reference: instructions execute in program order, one commit per accepted instruction
  always @(negedge clk) begin
    wr_t e;
    if (load_en) ref_rf[load_addr] = load_data;
    if (EN || done) check("done_eq_en", done, EN);
    if (EN) begin
      check("busy_in_write", busy, 1);
      if (exp_q.size() == 0) check("unexpected_write", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("wr_addr", DIR_WR, e.rd);
        check("wr_data", DI, e.val);
        check("ops_cnt", ops_cnt, ref_cnt);
        ref_rf[e.rd] = e.val;
        ref_cnt = ref_cnt + 8'd1;
      end
    end
    if (done) done_cnt++;
    if (!spacing_chk) have_prev = 0;
    if (rst_n && instr_valid && instr_ready) begin
      e.rd  = instr[1:0];
      e.val = force_alu ? 8'h5A : alu_f(instr[7:6], ref_rf[instr[5:4]], ref_rf[instr[3:2]]);
      exp_q.push_back(e);
      if (spacing_chk) begin
        if (have_prev) check("accept_spacing", cyc - prev_acc, PERIOD);
        have_prev = 1;
        prev_acc  = cyc;
      end
    end
    if (!rst_n) begin
      exp_q.delete();
      ref_cnt = '0;
    end
  end

  task automatic chk_zero(input string p);
    check({p, "_EN"}, EN, 0);
    check({p, "_done"}, done, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_ready"}, instr_ready, 0);
    check({p, "_dira"}, DIR_A, 0);
    check({p, "_dirb"}, DIR_B, 0);
    check({p, "_dirwr"}, DIR_WR, 0);
    check({p, "_di"}, DI, 0);
    check({p, "_aluop"}, ALU_OP, 0);
    check({p, "_ops"}, ops_cnt, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready_after", instr_ready, 1);
  endtask

  task automatic load_reg(input logic [1:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  // offer one instruction and return #1 after its accept edge (first READ cycle)
  task automatic issue_one(input logic [7:0] ins);
    int g = 0;
    instr = ins;
    instr_valid = 1'b1;
    do begin
      @(negedge clk);
      g++;
    end while (!instr_ready && g < 20);
    if (!instr_ready) check("issue_timeout", 0, 1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (busy && g < 20);
    check("drain_timeout", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic run_stream(input int n, input bit gaps);
    int  k = 0;
    int  guard = 0;
    bit  acc;
    spacing_chk = !gaps;
    instr = 8'($urandom);
    instr_valid = 1'b1;
    while (k < n && guard < n * 8 + 20) begin
      @(negedge clk);
      acc = instr_valid && instr_ready;
      @(posedge clk); #1;
      guard++;
      if (acc) k++;
      instr = 8'($urandom);
      instr_valid = gaps ? ($urandom_range(0, 3) != 0) : (k < n);
    end
    instr_valid = 1'b0;
    spacing_chk = 1'b0;
    check("stream_accepts", k, n);
  endtask

  initial begin
    do_reset();

    // single instruction with a forced ALU result, checked state by state
    force_alu = 1'b1;
    issue_one(8'b00_01_10_11);
    @(negedge clk);
    check("rd_dira", DIR_A, 1);
    check("rd_dirb", DIR_B, 2);
    check("rd_en", EN, 0);
    check("rd_busy", busy, 1);
    check("rd_ready", instr_ready, 0);
    @(negedge clk);
    check("ex_aluop", ALU_OP, 0);
    check("ex_en", EN, 0);
    check("ex_ready", instr_ready, 0);
    @(negedge clk);
    check("wr_en", EN, 1);
    check("wr_dirwr", DIR_WR, 3);
    check("wr_di", DI, 8'h5A);
    check("wr_done", done, 1);
    @(negedge clk);
    check("post_ops", ops_cnt, 1);
    check("post_en", EN, 0);
    check("post_done", done, 0);
    check("post_ready", instr_ready, 1);
    force_alu = 1'b0;
    @(posedge clk); #1;

    // read-after-write through the register file
    load_reg(2'd0, 8'd3);
    load_reg(2'd1, 8'd4);
    issue_one(8'b00_00_01_10);
    issue_one(8'b00_10_00_11);
    @(negedge clk);
    check("raw_doa", rf[DIR_A], 7);
    drain();
    check("raw_r3", rf[3], 10);

    // junk on instr/valid while busy must not disturb the latched fields
    issue_one(8'b01_11_00_10);
    for (int i = 0; i < 2; i++) begin
      instr = 8'($urandom);
      instr_valid = i[0] ? 1'b0 : 1'b1;
      @(negedge clk);
      check("junk_ready", instr_ready, 0);
      check("junk_dira", DIR_A, 3);
      check("junk_dirb", DIR_B, 0);
      if (i == 1) check("junk_aluop", ALU_OP, 1);
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    drain();

    // reset during EXEC aborts the write
    done_cnt = 0;
    issue_one(8'b00_00_00_01);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_zero("abort");
    @(posedge clk); #1;
    check("abort_ready", instr_ready, 1);
    check("abort_en", EN, 0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);

    // randomized traffic with gaps, then continuous traffic
    for (int r = 0; r < 4; r++) load_reg(2'(r), 8'($urandom));
    run_stream(40, 1'b1);
    drain();
    run_stream(30, 1'b0);
    drain();
    for (int r = 0; r < 4; r++) check("rf_final", rf[r], ref_rf[r]);

    // 256 instructions wrap ops_cnt
    do_reset();
    done_cnt = 0;
    run_stream(256, 1'b0);
    drain();
    check("wrap_done_cnt", done_cnt, 256);
    check("wrap_ops_cnt", ops_cnt, 0);
    check("wrap_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_op_ctrl.md
REG_OP_CTRL -- requirements
Module: reg_op_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (2-bit register address, 8-bit data, 2-bit opcode).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port instr_valid, input, 1 bit: instruction offered.
REQ-005 The block SHALL have port instr, input, 8 bits: {op[7:6], ra[5:4], rb[3:2], rd[1:0]}.
REQ-006 The block SHALL have port instr_ready, output, 1 bit: instruction accepted on edge where valid && ready.
REQ-007 The block SHALL have port alu_res, input, 8 bits: combinational ALU result from register-file DOA/DOB and ALU_OP.
REQ-008 The block SHALL have port DIR_A, output, 2 bits: register-file read address A.
REQ-009 The block SHALL have port DIR_B, output, 2 bits: register-file read address B.
REQ-010 The block SHALL have port DIR_WR, output, 2 bits: register-file write address.
REQ-011 The block SHALL have port DI, output, 8 bits: register-file write data.
REQ-012 The block SHALL have port EN, output, 1 bit: register-file write enable; 0 = read cycle, 1 = write cycle.
REQ-013 The block SHALL have port ALU_OP, output, 2 bits: opcode to ALU.
REQ-014 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-015 The block SHALL have port done, output, 1 bit: high for exactly the WRITE cycle of each instruction.
REQ-016 The block SHALL have port ops_cnt, output, 8 bits: count of completed instructions.

Function
REQ-017 The FSM SHALL have the states IDLE, READ, EXEC and WRITE; every output SHALL be registered or decoded only from registered state.
REQ-018 In IDLE, instr_ready SHALL be 1; on valid && ready, instr SHALL be latched and the FSM SHALL go to READ; instr_ready SHALL be 0 in READ and EXEC.
REQ-019 In READ, EN SHALL be 0, DIR_A SHALL equal the latched ra and DIR_B the latched rb; the next state SHALL be EXEC.
REQ-020 In EXEC, EN SHALL be 0 and ALU_OP SHALL equal the latched op; alu_res SHALL be captured into the result register at the closing edge; the next state SHALL be WRITE.
REQ-021 In WRITE, EN SHALL be 1, DIR_WR SHALL equal the latched rd and DI SHALL equal the captured result; done SHALL be 1; ops_cnt SHALL increment at the closing edge, wrapping 255 -> 0; the next state SHALL be IDLE.
REQ-022 The commit latency SHALL be 3 edges from the accept edge to the register-file write edge.
REQ-023 EN SHALL be 0 in every state except WRITE.
REQ-024 DIR_A, DIR_B, DIR_WR, DI and ALU_OP SHALL hold their last values outside the states that drive them.
REQ-025 ra, rb and rd SHALL be allowed to be equal (for example, r1 := f(r1, r1)); the read in READ SHALL see the value committed by any earlier WRITE.
REQ-026 instr and instr_valid SHALL be ignored while instr_ready is 0; instr_valid dropping mid-instruction SHALL have no effect.

Reset
REQ-027 While rst_n is low at a rising edge, the FSM SHALL go to IDLE and EN, done, busy, instr_ready, DIR_A, DIR_B, DIR_WR, DI, ALU_OP, ops_cnt and the result register SHALL all be 0.
REQ-028 A reset in any state SHALL abort the in-flight instruction with no register-file write; EN SHALL be 0 in the cycle following the reset edge.
REQ-029 instr_ready SHALL be 1 in the first cycle after rst_n returns high.

Configuration
REQ-030 When REG_OP_CTRL_BACK2BACK_EN is defined, instr_ready SHALL also be 1 in WRITE; an accept in WRITE SHALL go directly to READ, giving a throughput of 1 instruction per 3 cycles.
REQ-031 When REG_OP_CTRL_BACK2BACK_EN is undefined, instr_ready SHALL be 1 only in IDLE, giving a throughput of 1 instruction per 4 cycles.
REQ-032 In both modes, ports, latency and hazard behaviour SHALL be identical.

Verification
REQ-033 Reset, then instr=8'b00_01_10_11 with valid held and bench alu_res=8'h5A in EXEC -> READ shows DIR_A=1, DIR_B=2, EN=0; EXEC shows ALU_OP=0; WRITE shows EN=1, DIR_WR=3, DI=8'h5A, done=1; ops_cnt=1.
REQ-034 Back-to-back instructions with valid held continuously -> accepts every 4 cycles without the macro and every 3 cycles with it; EN is high for exactly 1 cycle per instruction.
REQ-035 With the bench register-file plus ALU model (op 00 = add), instr writes r2 := r0 + r1 (r0=3, r1=4), then instr reads r2 as ra -> second READ returns 7.
REQ-036 rst_n pulled low during EXEC -> no EN pulse, state IDLE, all outputs 0, instr_ready=1 next cycle.
REQ-037 Issue 256 instructions -> ops_cnt wraps to 0, with done pulses counted = 256.
REQ-038 Toggle instr_valid and change instr during READ and EXEC -> the latched fields are unchanged and no extra accept occurs.
